// File: rtl/arp_rx_parser.sv
// ARP receive parser: walks an Ethernet/ARP frame byte by byte and
// publishes the opcode and addresses of each well-formed packet.
module arp_rx_parser #(
    parameter int CHECK_HDR = 1
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] arp_op,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic [47:0] tha,
    output logic [31:0] tpa,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ETH_DEST_ADDR, ETH_SRC_ADDR, FRAME_TYPE, HW_TYPE,
        PROT_TYPE, HW_LEN, PROT_LEN, ARP_OP, ARP_SRC_ADDR,
        ARP_SRC_IP, ARP_DEST_ADDR, ARP_DEST_IP, END, DROP
    } state_t;

    state_t      state, state_n;
    logic [2:0]  blk_cnt, cnt_n;
    logic [2:0]  field_len;
    logic [7:0]  prev_sh;
    logic [15:0] op_sh;
    logic [47:0] sha_sh, tha_sh;
    logic [31:0] spa_sh, tpa_sh;
    logic [15:0] hword;
    logic        hdr_ok, last, done_n, err_n;

    assign busy  = (state != IDLE);
    assign hword = {prev_sh, rx_data};
    assign last  = (blk_cnt == field_len - 3'd1);

    always_comb begin
        field_len = 3'd1;
        unique case (state)
            ETH_DEST_ADDR, ETH_SRC_ADDR,
            ARP_SRC_ADDR, ARP_DEST_ADDR: field_len = 3'd6;
            FRAME_TYPE, HW_TYPE,
            PROT_TYPE, ARP_OP:           field_len = 3'd2;
            ARP_SRC_IP, ARP_DEST_IP:     field_len = 3'd4;
            default:                     field_len = 3'd1;
        endcase
    end

    // Two-byte fields are judged on the previous byte plus the current one
    always_comb begin
        hdr_ok = 1'b1;
        unique case (state)
            FRAME_TYPE: hdr_ok = (hword == 16'h0806);
            HW_TYPE:    hdr_ok = (hword == 16'h0001);
            PROT_TYPE:  hdr_ok = (hword == 16'h0800);
            HW_LEN:     hdr_ok = (rx_data == 8'h06);
            PROT_LEN:   hdr_ok = (rx_data == 8'h04);
            ARP_OP:     hdr_ok = (hword == 16'h0001) ||
                                 (hword == 16'h0002);
            default:    hdr_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = blk_cnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_n = ETH_DEST_ADDR;
                    cnt_n   = 3'd1;
                end
            end
            END, DROP: begin
                if (!rx_valid) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end
            end
            default: begin
                if (!rx_valid) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                    err_n   = 1'b1;
                end else if (last) begin
                    cnt_n = 3'd0;
                    if ((CHECK_HDR != 0) && !hdr_ok) begin
                        state_n = DROP;
                        err_n   = 1'b1;
                    end else begin
                        state_n = state_t'(state + 4'd1);
                        done_n  = (state == ARP_DEST_IP);
                    end
                end else begin
                    cnt_n = blk_cnt + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state    <= IDLE;
            blk_cnt  <= 3'd0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            prev_sh  <= '0;
            op_sh    <= '0;
            sha_sh   <= '0;
            spa_sh   <= '0;
            tha_sh   <= '0;
            tpa_sh   <= '0;
            arp_op   <= '0;
            sha      <= '0;
            spa      <= '0;
            tha      <= '0;
            tpa      <= '0;
        end else begin
            state    <= state_n;
            blk_cnt  <= cnt_n;
            pkt_done <= done_n;
            pkt_err  <= err_n;
            if (rx_valid) begin
                prev_sh <= rx_data;
                unique case (state)
                    ARP_OP:        op_sh  <= {op_sh[7:0], rx_data};
                    ARP_SRC_ADDR:  sha_sh <= {sha_sh[39:0], rx_data};
                    ARP_SRC_IP:    spa_sh <= {spa_sh[23:0], rx_data};
                    ARP_DEST_ADDR: tha_sh <= {tha_sh[39:0], rx_data};
                    ARP_DEST_IP:   tpa_sh <= {tpa_sh[23:0], rx_data};
                    default: ;
                endcase
            end
            // Final tpa byte is still on the bus, so splice it in directly
            if (done_n) begin
                arp_op <= op_sh;
                sha    <= sha_sh;
                spa    <= spa_sh;
                tha    <= tha_sh;
                tpa    <= {tpa_sh[23:0], rx_data};
            end
        end
    end

endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: two instances (header check on and off)
// share one byte stream and are compared to a frame-level model.
module tb_arp_rx_parser;

    logic        clk = 1'b0;
    logic        areset, rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] op_v  [2];
    logic [47:0] sha_v [2];
    logic [31:0] spa_v [2];
    logic [47:0] tha_v [2];
    logic [31:0] tpa_v [2];
    logic [1:0]  done_v, err_v, busy_v;

    int errors = 0;
    int checks = 0;
    logic [7:0]   fr [64];
    logic [175:0] exp_f [2];

    always #5 clk = ~clk;

    arp_rx_parser #(.CHECK_HDR(1)) dut (
        .clk(clk), .areset(areset), .rx_valid(rx_valid), .rx_data(rx_data),
        .arp_op(op_v[0]), .sha(sha_v[0]), .spa(spa_v[0]), .tha(tha_v[0]),
        .tpa(tpa_v[0]), .pkt_done(done_v[0]), .pkt_err(err_v[0]),
        .busy(busy_v[0])
    );

    arp_rx_parser #(.CHECK_HDR(0)) dut_nc (
        .clk(clk), .areset(areset), .rx_valid(rx_valid), .rx_data(rx_data),
        .arp_op(op_v[1]), .sha(sha_v[1]), .spa(spa_v[1]), .tha(tha_v[1]),
        .tpa(tpa_v[1]), .pkt_done(done_v[1]), .pkt_err(err_v[1]),
        .busy(busy_v[1])
    );

    function automatic logic [175:0] got(input int d);
        return {op_v[d], sha_v[d], spa_v[d], tha_v[d], tpa_v[d]};
    endfunction

    // Bytes 20..41 are op, sha, spa, tha, tpa back to back
    function automatic logic [175:0] frame_fields();
        logic [175:0] v = '0;
        for (int i = 20; i < 42; i++) v = {v[167:0], fr[i]};
        return v;
    endfunction

    // Index of the last byte of the first bad header field, if consumed
    function automatic int hdr_fail(input int n, input bit chk);
        int k;
        if (!chk) return -1;
        if ({fr[12], fr[13]} != 16'h0806) k = 13;
        else if ({fr[14], fr[15]} != 16'h0001) k = 15;
        else if ({fr[16], fr[17]} != 16'h0800) k = 17;
        else if (fr[18] != 8'h06) k = 18;
        else if (fr[19] != 8'h04) k = 19;
        else if ({fr[20], fr[21]} != 16'h0001 &&
                 {fr[20], fr[21]} != 16'h0002) k = 21;
        else k = -1;
        return (k >= n) ? -1 : k;
    endfunction

    task automatic build_valid();
        for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
        fr[12] = 8'h08; fr[13] = 8'h06;
        fr[14] = 8'h00; fr[15] = 8'h01;
        fr[16] = 8'h08; fr[17] = 8'h00;
        fr[18] = 8'h06; fr[19] = 8'h04;
        fr[20] = 8'h00; fr[21] = 8'($urandom_range(1, 2));
    endtask

    // Sample i shows the cycle after byte i (or idle slot i) was presented
    task automatic send_frame(input int n, input string name);
        int e_done [2], e_err [2], f_done [2], f_err [2];
        int n_done [2], n_err [2];
        bit ovl [2], hold_bad [2];
        logic b_hi [2], b_lo [2];
        logic [175:0] newf [2];
        for (int d = 0; d < 2; d++) begin
            int k = hdr_fail(n, d == 0);
            e_done[d] = -1; e_err[d] = -1;
            if (k >= 0) e_err[d] = k;
            else if (n < 42) e_err[d] = n;
            else e_done[d] = 41;
            newf[d] = (e_done[d] >= 0) ? frame_fields() : exp_f[d];
            f_done[d] = -1; f_err[d] = -1; n_done[d] = 0; n_err[d] = 0;
            ovl[d] = 0; hold_bad[d] = 0; b_hi[d] = 1'bx; b_lo[d] = 1'bx;
        end
        for (int i = 0; i <= n + 2; i++) begin
            rx_valid = (i < n);
            rx_data  = (i < n) ? fr[i] : 8'($urandom);
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                logic [175:0] now_exp;
                if (done_v[d] === 1'b1) begin
                    n_done[d]++;
                    if (f_done[d] < 0) f_done[d] = i;
                end
                if (err_v[d] === 1'b1) begin
                    n_err[d]++;
                    if (f_err[d] < 0) f_err[d] = i;
                end
                if (done_v[d] === 1'b1 && err_v[d] === 1'b1) ovl[d] = 1;
                now_exp = (e_done[d] >= 0 && i >= e_done[d]) ? newf[d] : exp_f[d];
                if (got(d) !== now_exp) hold_bad[d] = 1;
                if (i == n - 1) b_hi[d] = busy_v[d];
                if (i == n) b_lo[d] = busy_v[d];
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (f_done[d] !== e_done[d]) begin
                errors++;
                $display("FAIL %s dut%0d done_idx got %0d exp %0d", name, d, f_done[d], e_done[d]);
            end
            checks++;
            if (f_err[d] !== e_err[d]) begin
                errors++;
                $display("FAIL %s dut%0d err_idx got %0d exp %0d", name, d, f_err[d], e_err[d]);
            end
            checks++;
            if (n_done[d] + n_err[d] !== 1) begin
                errors++;
                $display("FAIL %s dut%0d pulse_count got %0d exp 1", name, d, n_done[d] + n_err[d]);
            end
            checks++;
            if (ovl[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d done_err_overlap got 1 exp 0", name, d);
            end
            checks++;
            if (hold_bad[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d outputs got %h exp %h", name, d, got(d), newf[d]);
            end
            checks++;
            if (b_hi[d] !== 1'b1 || b_lo[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d busy got %b/%b exp 1/0", name, d, b_hi[d], b_lo[d]);
            end
            exp_f[d] = newf[d];
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        rx_valid = 1'b1;
        repeat (2) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== '0) begin
                errors++;
                $display("FAIL reset dut%0d outputs got %h exp 0", d, got(d));
            end
            checks++;
            if ({done_v[d], err_v[d], busy_v[d]} !== 3'b000) begin
                errors++;
                $display("FAIL reset dut%0d done/err/busy got %b%b%b exp 000",
                         d, done_v[d], err_v[d], busy_v[d]);
            end
            exp_f[d] = '0;
        end
        areset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_request();
        logic [7:0] b [20] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h0A, 8'h00, 8'h00, 8'h01,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h0A, 8'h00, 8'h00, 8'h02};
        build_valid();
        fr[21] = 8'h01;
        for (int i = 0; i < 20; i++) fr[22 + i] = b[i];
        send_frame(42, "request");
        checks++;
        if (op_v[0] !== 16'h0001 || sha_v[0] !== 48'h020000000001 ||
            spa_v[0] !== 32'h0A000001 || tpa_v[0] !== 32'h0A000002) begin
            errors++;
            $display("FAIL request_fields got %h %h %h %h exp 0001 020000000001 0a000001 0a000002",
                     op_v[0], sha_v[0], spa_v[0], tpa_v[0]);
        end
    endtask

    task automatic test_bad_type();
        build_valid();
        fr[13] = 8'h00;
        send_frame(42, "bad_type");
    endtask

    task automatic test_padding();
        build_valid();
        send_frame(60, "padding");
    endtask

    task automatic test_short();
        build_valid();
        send_frame(26, "short");
    endtask

    task automatic test_mid_reset();
        build_valid();
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'b1;
            rx_data  = fr[i];
            @(posedge clk); #1;
        end
        areset  = 1'b1;
        rx_data = fr[20];
        @(posedge clk); #1;
        areset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== '0 || busy_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset dut%0d outputs/busy got %h/%b exp 0/0",
                         d, got(d), busy_v[d]);
            end
            exp_f[d] = '0;
        end
        for (int i = 0; i < 21; i++) fr[i] = fr[i + 21];
        send_frame(21, "reset_tail");
        build_valid();
        send_frame(42, "after_reset");
    endtask

    task automatic test_nocheck();
        build_valid();
        fr[15] = 8'h06;
        fr[20] = 8'h00;
        fr[21] = 8'h09;
        send_frame(42, "nocheck");
        checks++;
        if (op_v[1] !== 16'h0009) begin
            errors++;
            $display("FAIL nocheck_op got %h exp 0009", op_v[1]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int n = 42;
            int m = $urandom_range(0, 4);
            build_valid();
            if (m == 1) fr[$urandom_range(12, 21)] ^= 8'($urandom_range(1, 255));
            else if (m == 2) n = $urandom_range(1, 41);
            else if (m == 3) n = $urandom_range(43, 64);
            else if (m == 4) begin
                fr[20] = 8'($urandom_range(0, 1));
                fr[21] = 8'($urandom);
            end
            send_frame(n, "random");
        end
    endtask

    initial begin
        areset   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_request();
        test_bad_type();
        test_padding();
        test_short();
        test_mid_reset();
        test_nocheck();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
